// File: rtl/instruction_fetch_pkg.sv
// Shared CPU fetch types.
//   fetch_state_t : fetch FSM states (IDLE, REQ, WAIT)
//   INSTR_NOP     : canonical nop encoding (addi x0, x0, 0)
//   fetch_entry_t : one buffered instruction word plus the address it was fetched from
//   word_align()  : clears the two byte-offset bits of an address
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Instruction buffer between the memory response path and the decoder.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset (empties and clears storage)
//   flush_i       : drop every entry; wins over push_i and pop_i
//   push_i        : write wdata_i (accepted when not full, or when full and popping)
//   pop_i         : retire the head entry (ignored when empty)
//   wdata_i       : entry to write
//   rdata_o       : head entry, valid whenever empty_o is low
//   full_o, empty_o, count_o : occupancy status
module instruction_fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  fetch_entry_t    wdata_i,
  output fetch_entry_t    rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  fetch_entry_t    mem_q [Depth];
  fetch_entry_t    mem_d [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    do_pop  = pop_i && !empty_o;
    // A full buffer can still take a word when the head leaves in the same cycle.
    do_push = push_i && (!full_o || do_pop);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = wdata_i;
        wptr_d        = wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the fetch PC, reads instruction memory with a single
// outstanding req/gnt/rvalid transaction, buffers returned words and hands them to the
// decoder over valid/ready. Redirects from execute flush buffered and in-flight words.
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   imem_req/imem_addr             : read request, held until imem_gnt
//   imem_gnt/imem_rvalid/imem_rdata: memory grant and read response
//   redirect/redirect_pc           : new fetch PC from execute
//   instr_valid/instr_ready        : downstream handshake
//   instruction/instr_pc           : head instruction word and its address
//   fetch_misaligned               : only with FETCH_MISALIGN_CHECK_EN; one-cycle pulse after a
//                                    redirect whose target is not word aligned
// Build option FETCH_MISALIGN_CHECK_EN: a misaligned redirect stalls fetch until the next
// aligned redirect. Without it the byte-offset bits are simply cleared.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [CntW:0]   DepthOcc = (CntW + 1)'(FIFO_DEPTH);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         discard_q, discard_d;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic [CntW:0]   occ_after_rsp;
  fetch_entry_t    push_entry, head_entry;

  // fetch_halt: fetching is currently stalled; halt_next: stall state after this cycle.
  logic fetch_halt, halt_next;
  fetch_state_t resume_state;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic halt_q;
  logic misaligned_q, misaligned_d;

  assign misaligned_d     = redirect && (redirect_pc[1:0] != 2'b00);
  assign halt_next        = redirect ? misaligned_d : halt_q;
  assign fetch_halt       = halt_q;
  assign fetch_misaligned = misaligned_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halt_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      halt_q       <= halt_next;
      misaligned_q <= misaligned_d;
    end
  end
`else
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign halt_next           = 1'b0;
  assign fetch_halt          = 1'b0;
`endif

  assign resume_state = halt_next ? IDLE : REQ;

  assign fifo_pop   = instr_valid && instr_ready;
  assign push_entry = '{instruction: imem_rdata, pc: req_pc_q};

  // Occupancy once the current response (if kept) and any pop have landed; pop implies
  // a non-empty buffer so this cannot underflow.
  assign occ_after_rsp = {1'b0, fifo_count} + (CntW + 1)'(!discard_q)
                       - (CntW + 1)'(fifo_pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    fifo_push  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // No request is outstanding here, so occupancy is just the buffer count.
        if (!fetch_halt && (fifo_count < DepthCnt)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (imem_gnt) begin
          state_d    = WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          fifo_push = !discard_q;
          discard_d = 1'b0;
          state_d   = (!fetch_halt && (occ_after_rsp < DepthOcc)) ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides the normal flow; the buffer is flushed by the FIFO itself.
    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
      fifo_push  = 1'b0;
      unique case (state_q)
        WAIT: begin
          if (imem_rvalid) begin
            state_d   = resume_state;
            discard_d = 1'b0;
          end else begin
            // Response still in flight: stay and drop it when it arrives.
            state_d   = WAIT;
            discard_d = 1'b1;
          end
        end
        REQ: begin
          if (imem_gnt) begin
            // Old address was accepted this cycle; its response must be dropped.
            state_d   = WAIT;
            discard_d = 1'b1;
            req_pc_d  = fetch_pc_q;
          end else begin
            state_d = resume_state;
          end
        end
        default: state_d = resume_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
    end
  end

  instruction_fetch_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (redirect),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = !fifo_empty;
  assign instruction = head_entry.instruction;
  assign instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a bench-side memory answers requests with a
// fixed function of the address, and delivered instructions are checked against program
// order (sequential +4, restarting at each redirect target).
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  instruction_fetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .instr_pc    (instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model knobs and state.
  int          gnt_pct = 100;
  int          rv_min  = 1;
  int          rv_max  = 1;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt  = 0;

  // Per-cycle observations (sampled at negedge).
  logic        o_req, o_valid, o_pop, o_grant, o_overlap, o_mis;
  logic [31:0] o_addr, o_pc, o_ins;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // One clock cycle: drive inputs just after posedge, sample at negedge, advance memory.
  task automatic cycle(input logic rdy, input logic rd, input logic [31:0] rpc);
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rvalid = mem_pend && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    imem_gnt    = imem_req && ($urandom_range(99) < gnt_pct);
    @(negedge clk);
    o_req     = imem_req;
    o_addr    = imem_addr;
    o_valid   = instr_valid;
    o_pc      = instr_pc;
    o_ins     = instruction;
    o_pop     = instr_valid && instr_ready;
    o_grant   = imem_req && imem_gnt;
    o_overlap = o_grant && mem_pend;
`ifdef FETCH_MISALIGN_CHECK_EN
    o_mis = fetch_misaligned;
`else
    o_mis = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (imem_rvalid) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (o_grant) begin
      mem_pend = 1'b1;
      mem_addr = o_addr;
      mem_cnt  = int'($urandom_range(rv_max, rv_min)) - 1;
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    mem_pend = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    gnt_pct = 100; rv_min = 1; rv_max = 1;
    reset_dut();
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, '0);
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, '0);
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, '0);
      n_tests++;
      if (o_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", o_req); end
      n_tests++;
      if (o_addr !== RST_PC) begin
        n_fail++; $display("FAIL reset_addr: got %h want %h", o_addr, RST_PC);
      end
      n_tests++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
      n_tests++;
      if (o_ins !== 32'h0 || o_pc !== 32'h0) begin
        n_fail++; $display("FAIL reset_head: got ins %h pc %h want 0 0", o_ins, o_pc);
      end
    end
    mem_pend = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    int first_req;
    int first_valid;
    logic [31:0] pcs[$];
    logic [31:0] ins[$];
    first_req = -1; first_valid = -1;
    gnt_pct = 100; rv_min = 1; rv_max = 1;
    reset_dut();
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b1, 1'b0, '0);
      if (o_req && first_req < 0) first_req = k;
      if (o_valid && first_valid < 0) first_valid = k;
      if (o_pop) begin pcs.push_back(o_pc); ins.push_back(o_ins); end
    end
    n_tests++;
    if (first_req != 2) begin n_fail++; $display("FAIL first_req: got %0d want 2", first_req); end
    // Visible in cycle 4 = after the third clock edge following release.
    n_tests++;
    if (first_valid != 4) begin
      n_fail++; $display("FAIL first_valid: got %0d want 4", first_valid);
    end
    n_tests++;
    if (pcs.size() != 5) begin
      n_fail++; $display("FAIL throughput: got %0d pops want 5", pcs.size());
    end
    for (int i = 0; i < 3 && i < pcs.size(); i++) begin
      n_tests++;
      if (pcs[i] !== 32'(4 * i) || ins[i] !== mem_word(32'(4 * i))) begin
        n_fail++;
        $display("FAIL order_%0d: got pc %h ins %h want pc %h ins %h", i, pcs[i], ins[i],
                 32'(4 * i), mem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure();
    int grants;
    logic [31:0] pcs[$];
    grants = 0;
    gnt_pct = 100; rv_min = 1; rv_max = 1;
    reset_dut();
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b0, 1'b0, '0);
      if (o_grant) grants++;
      if (k >= 7) begin
        n_tests++;
        if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_ins !== mem_word(32'h0) || o_req !== 1'b0)
        begin
          n_fail++;
          $display("FAIL bp_hold_%0d: got valid %b pc %h req %b want 1 00000000 0", k, o_valid,
                   o_pc, o_req);
        end
      end
    end
    n_tests++;
    if (grants != 2) begin n_fail++; $display("FAIL bp_grants: got %0d want 2", grants); end
    for (int k = 0; k < 20 && pcs.size() < 3; k++) begin
      cycle(1'b1, 1'b0, '0);
      if (o_pop) pcs.push_back(o_pc);
    end
    n_tests++;
    if (pcs.size() != 3) begin
      n_fail++; $display("FAIL bp_release: got %0d pops want 3", pcs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (pcs[i] !== 32'(4 * i)) begin
          n_fail++; $display("FAIL bp_order_%0d: got %h want %h", i, pcs[i], 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_gnt_stall();
    int grants;
    logic [31:0] gaddr;
    logic        popped;
    grants = 0; gaddr = 32'hFFFF_FFFF; popped = 1'b0;
    gnt_pct = 0; rv_min = 1; rv_max = 1;
    reset_dut();
    cycle(1'b1, 1'b0, '0);
    for (int k = 2; k <= 5; k++) begin
      cycle(1'b1, 1'b0, '0);
      n_tests++;
      if (o_req !== 1'b1 || o_addr !== 32'h0) begin
        n_fail++; $display("FAIL stall_hold_%0d: got req %b addr %h want 1 00000000", k, o_req,
                           o_addr);
      end
    end
    gnt_pct = 100;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b0, '0);
      if (o_pop) begin popped = 1'b1; break; end
      if (o_grant) begin grants++; gaddr = o_addr; end
    end
    n_tests++;
    if (!popped || grants != 1 || gaddr !== 32'h0 || o_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL stall_txn: got popped %b grants %0d addr %h pc %h want 1 1 0 0", popped,
               grants, gaddr, o_pc);
    end
  endtask

  task automatic test_redirect();
    logic found;
    logic popped;
    found = 1'b0; popped = 1'b0;
    gnt_pct = 100; rv_min = 3; rv_max = 3;
    reset_dut();
    for (int k = 0; k < 40 && !found; k++) begin
      cycle(1'b1, 1'b0, '0);
      if (o_grant && o_addr == 32'h8) found = 1'b1;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL redir_setup: got no grant for 8 want grant"); end
    cycle(1'b1, 1'b1, 32'h100);
    cycle(1'b1, 1'b0, '0);
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %b want 0", o_valid); end
    if (o_pop) popped = 1'b1;
    for (int k = 0; k < 30 && !popped; k++) begin
      cycle(1'b1, 1'b0, '0);
      if (o_pop) popped = 1'b1;
    end
    n_tests++;
    if (!popped || o_pc !== 32'h100 || o_ins !== mem_word(32'h100)) begin
      n_fail++; $display("FAIL redir_target: got popped %b pc %h want 1 00000100", popped, o_pc);
    end
  endtask

  task automatic test_misalign();
    logic popped;
    int   pulses;
    int   reqs;
    popped = 1'b0; pulses = 0; reqs = 0;
    gnt_pct = 100; rv_min = 1; rv_max = 1;
    reset_dut();
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h203);
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b0, '0);
      if (o_mis) pulses++;
      if (o_req) reqs++;
      if (o_pop) popped = 1'b1;
      if (k == 0) begin
        n_tests++;
        if (o_mis !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b want 1", o_mis); end
      end
    end
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL mis_pulses: got %0d want 1", pulses); end
    n_tests++;
    if (reqs != 0 || popped) begin
      n_fail++; $display("FAIL mis_halt: got reqs %0d popped %b want 0 0", reqs, popped);
    end
    cycle(1'b1, 1'b1, 32'h300);
    popped = 1'b0;
    for (int k = 0; k < 20 && !popped; k++) begin
      cycle(1'b1, 1'b0, '0);
      if (k == 0) begin
        n_tests++;
        if (o_mis !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", o_mis); end
      end
      if (o_pop) popped = 1'b1;
    end
    n_tests++;
    if (!popped || o_pc !== 32'h300) begin
      n_fail++; $display("FAIL mis_resume: got popped %b pc %h want 1 00000300", popped, o_pc);
    end
`else
    for (int k = 0; k < 20 && !popped; k++) begin
      cycle(1'b1, 1'b0, '0);
      if (o_grant && reqs == 0) begin
        reqs++;
        n_tests++;
        if (o_addr !== 32'h200) begin
          n_fail++; $display("FAIL align_grant: got %h want 00000200", o_addr);
        end
      end
      if (o_pop) popped = 1'b1;
    end
    n_tests++;
    if (!popped || o_pc !== 32'h200 || o_ins !== mem_word(32'h200)) begin
      n_fail++; $display("FAIL align_target: got popped %b pc %h want 1 00000200", popped, o_pc);
    end
    n_tests++;
    if (pulses != 0) begin n_fail++; $display("FAIL align_pulse: got %0d want 0", pulses); end
`endif
  endtask

  task automatic test_reset_mid();
    logic found;
    logic popped;
    found = 1'b0; popped = 1'b0;
    gnt_pct = 100; rv_min = 2; rv_max = 2;
    reset_dut();
    for (int k = 0; k < 40 && !found; k++) begin
      cycle(1'b1, 1'b0, '0);
      if (o_grant && o_addr == 32'h8) found = 1'b1;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL rmid_setup: got no grant for 8 want grant"); end
    rst_n = 1'b0;
    cycle(1'b1, 1'b0, '0);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, '0);   // stale rvalid for 0x8 arrives here
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: got %b want 0", o_valid); end
    cycle(1'b1, 1'b0, '0);
    n_tests++;
    if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== RST_PC) begin
      n_fail++; $display("FAIL rmid_refetch: got valid %b req %b addr %h want 0 1 %h", o_valid,
                         o_req, o_addr, RST_PC);
    end
    for (int k = 0; k < 20 && !popped; k++) begin
      cycle(1'b1, 1'b0, '0);
      if (o_pop) popped = 1'b1;
    end
    n_tests++;
    if (!popped || o_pc !== RST_PC || o_ins !== mem_word(RST_PC)) begin
      n_fail++; $display("FAIL rmid_first: got popped %b pc %h want 1 %h", popped, o_pc, RST_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic        prev_rd;
    logic        prev_hold;
    logic [31:0] prev_addr;
    logic        rdy, rd;
    logic [31:0] rpc;
    int          pops;
    exp_pc = RST_PC; prev_rd = 1'b0; prev_hold = 1'b0; prev_addr = '0; pops = 0;
    gnt_pct = 60; rv_min = 1; rv_max = 3;
    reset_dut();
    for (int k = 0; k < 1500; k++) begin
      rdy = ($urandom_range(99) < 70);
      rd  = ($urandom_range(99) < 4);
      rpc = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC);
      cycle(rdy, rd, rpc);
      if (prev_rd) begin
        n_tests++;
        if (o_valid !== 1'b0) begin
          n_fail++; $display("FAIL rnd_flush_%0d: got %b want 0", k, o_valid);
        end
      end
      if (prev_hold) begin
        n_tests++;
        if (o_req !== 1'b1 || o_addr !== prev_addr) begin
          n_fail++; $display("FAIL rnd_hold_%0d: got req %b addr %h want 1 %h", k, o_req, o_addr,
                             prev_addr);
        end
      end
      if (o_grant) begin
        n_tests++;
        if (o_overlap || o_addr[1:0] !== 2'b00) begin
          n_fail++; $display("FAIL rnd_grant_%0d: got overlap %b addr %h want 0 aligned", k,
                             o_overlap, o_addr);
        end
      end
      if (o_pop) begin
        pops++;
        n_tests++;
        if (o_pc !== exp_pc || o_ins !== mem_word(exp_pc)) begin
          n_fail++; $display("FAIL rnd_pop_%0d: got pc %h ins %h want pc %h ins %h", k, o_pc,
                             o_ins, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (rd) exp_pc = rpc;
      prev_rd   = rd;
      prev_hold = o_req && !o_grant && !rd;
      prev_addr = o_addr;
    end
    n_tests++;
    if (pops < 50) begin n_fail++; $display("FAIL rnd_progress: got %0d pops want >= 50", pops); end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_latency();
    test_backpressure();
    test_gnt_stall();
    test_redirect();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
